// File: rtl/mem_wb_reg.sv
// ---------------------------------------------------------------------------
// mem_wb_reg
//
// Pipeline register between the MEM and WB stages. It captures the MEM-stage
// results and control fields on every rising edge, supports hold (stall) and
// squash (flush), qualifies the register-file write enable with the slot's
// valid bit, and counts instructions leaving the WB stage.
//
// Ports
//   clk           in   1   rising-edge clock
//   rst           in   1   synchronous active-high reset
//   stall         in   1   hold current WB-stage contents
//   flush         in   1   squash the instruction entering WB
//   valid_in      in   1   MEM stage holds a real instruction
//   alu_out_in    in  16   ALU result from MEM
//   dm_data_in    in  16   data-memory read data
//   PC_plus_2_in  in  16   link address
//   Imm2_in       in   9   LLI immediate
//   MemtoReg_in   in   2   write-back select code
//   RegWrite_in   in   1   register-write request
//   rd_in         in   3   destination register index
//   alu_out, dm_data, PC_plus_2   out 16   registered copies
//   Imm2          out  9   registered copy
//   MemtoReg      out  2   registered copy
//   rd            out  3   registered copy
//   valid_out     out  1   WB stage holds a real instruction
//   RegWrite      out  1   write enable, registered RegWrite_in AND valid_out
//   retire_count  out 16   retired-instruction counter (wraps)
//
// Slot semantics: valid_in/valid_out mark whether a stage slot carries a real
// instruction. There is no back-pressure handshake; stall simply freezes the
// WB slot, and an instruction "retires" on any edge where a valid WB slot is
// not frozen (it is either replaced by a load or squashed by a flush).
// Per-edge priority is rst > flush > stall > load.
// ---------------------------------------------------------------------------
module mem_wb_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        valid_in,
  input  logic [15:0] alu_out_in,
  input  logic [15:0] dm_data_in,
  input  logic [15:0] PC_plus_2_in,
  input  logic [8:0]  Imm2_in,
  input  logic [1:0]  MemtoReg_in,
  input  logic        RegWrite_in,
  input  logic [2:0]  rd_in,
  output logic [15:0] alu_out,
  output logic [15:0] dm_data,
  output logic [15:0] PC_plus_2,
  output logic [8:0]  Imm2,
  output logic [1:0]  MemtoReg,
  output logic [2:0]  rd,
  output logic        valid_out,
  output logic        RegWrite,
  output logic [15:0] retire_count
);

  logic [15:0] r_alu_out;
  logic [15:0] r_dm_data;
  logic [15:0] r_pc_plus_2;
  logic [8:0]  r_imm2;
  logic [1:0]  r_memtoreg;
  logic [2:0]  r_rd;
  logic        r_valid;
  logic        r_regwrite;
  logic [15:0] r_retire_count;

  // The WB instruction leaves the stage whenever it is valid and not frozen.
  // A flush on a non-stalled edge still retires the outgoing instruction;
  // the flush only squashes the one coming in.
  logic w_retire;
  assign w_retire = r_valid & ~stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_out      <= '0;
      r_dm_data      <= '0;
      r_pc_plus_2    <= '0;
      r_imm2         <= '0;
      r_memtoreg     <= '0;
      r_rd           <= '0;
      r_valid        <= 1'b0;
      r_regwrite     <= 1'b0;
      r_retire_count <= '0;
    end else begin
      if (w_retire) begin
        r_retire_count <= r_retire_count + 16'd1;  // free-running wrap
      end

      if (flush) begin
        // Flush overrides stall: the slot becomes a clean all-zero bubble.
        r_alu_out   <= '0;
        r_dm_data   <= '0;
        r_pc_plus_2 <= '0;
        r_imm2      <= '0;
        r_memtoreg  <= '0;
        r_rd        <= '0;
        r_valid     <= 1'b0;
        r_regwrite  <= 1'b0;
      end else if (!stall) begin
        r_alu_out   <= alu_out_in;
        r_dm_data   <= dm_data_in;
        r_pc_plus_2 <= PC_plus_2_in;
        r_imm2      <= Imm2_in;
        r_memtoreg  <= MemtoReg_in;
        r_rd        <= rd_in;
        r_valid     <= valid_in;
        r_regwrite  <= RegWrite_in;
      end
    end
  end

  assign alu_out      = r_alu_out;
  assign dm_data      = r_dm_data;
  assign PC_plus_2    = r_pc_plus_2;
  assign Imm2         = r_imm2;
  assign MemtoReg     = r_memtoreg;
  assign rd           = r_rd;
  assign valid_out    = r_valid;
  // Both operands are flops, so no input reaches this output combinationally.
  assign RegWrite     = r_regwrite & r_valid;
  assign retire_count = r_retire_count;

endmodule

// File: tb/tb_mem_wb_reg.sv
module tb_mem_wb_reg;

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        valid_in;
  logic [15:0] alu_out_in;
  logic [15:0] dm_data_in;
  logic [15:0] PC_plus_2_in;
  logic [8:0]  Imm2_in;
  logic [1:0]  MemtoReg_in;
  logic        RegWrite_in;
  logic [2:0]  rd_in;
  logic [15:0] alu_out;
  logic [15:0] dm_data;
  logic [15:0] PC_plus_2;
  logic [8:0]  Imm2;
  logic [1:0]  MemtoReg;
  logic [2:0]  rd;
  logic        valid_out;
  logic        RegWrite;
  logic [15:0] retire_count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_wb_reg dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .valid_in     (valid_in),
    .alu_out_in   (alu_out_in),
    .dm_data_in   (dm_data_in),
    .PC_plus_2_in (PC_plus_2_in),
    .Imm2_in      (Imm2_in),
    .MemtoReg_in  (MemtoReg_in),
    .RegWrite_in  (RegWrite_in),
    .rd_in        (rd_in),
    .alu_out      (alu_out),
    .dm_data      (dm_data),
    .PC_plus_2    (PC_plus_2),
    .Imm2         (Imm2),
    .MemtoReg     (MemtoReg),
    .rd           (rd),
    .valid_out    (valid_out),
    .RegWrite     (RegWrite),
    .retire_count (retire_count)
  );

  // ---------------- vector types ----------------
  // For stimulus, rw is RegWrite_in; for expectations, rw is the RegWrite output.
  typedef struct packed {
    logic        valid;
    logic        rw;
    logic [2:0]  rd;
    logic [1:0]  m2r;
    logic [8:0]  imm;
    logic [15:0] alu;
    logic [15:0] dm;
    logic [15:0] pc;
  } slot_t;

  typedef struct packed {
    logic [31:0] tag;
    slot_t       s;
    logic [15:0] rc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors_applied = 0;
  int   miscompares     = 0;
  int   vec_id          = 0;

  function automatic slot_t mk(input logic v, input logic w, input logic [2:0] r,
                               input logic [1:0] m, input logic [8:0] im,
                               input logic [15:0] a, input logic [15:0] d,
                               input logic [15:0] p);
    slot_t s;
    s.valid = v; s.rw = w; s.rd = r; s.m2r = m; s.imm = im;
    s.alu = a; s.dm = d; s.pc = p;
    return s;
  endfunction

  // ---------------- driver ----------------
  // Inputs change 2 time units after a rising edge; the expectation describes
  // the outputs after the next rising edge.
  task automatic drive(input logic r, input logic st, input logic fl,
                       input slot_t in, input slot_t ex, input logic [15:0] rc);
    exp_t e;
    @(posedge clk);
    #2;
    rst          = r;
    stall        = st;
    flush        = fl;
    valid_in     = in.valid;
    RegWrite_in  = in.rw;
    rd_in        = in.rd;
    MemtoReg_in  = in.m2r;
    Imm2_in      = in.imm;
    alu_out_in   = in.alu;
    dm_data_in   = in.dm;
    PC_plus_2_in = in.pc;
    vec_id++;
    e.tag = vec_id;
    e.s   = ex;
    e.rc  = rc;
    exp_q.push_back(e);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    exp_t  e;
    slot_t act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = mk(valid_out, RegWrite, rd, MemtoReg, Imm2, alu_out, dm_data, PC_plus_2);
        vectors_applied++;
        if (act !== e.s || retire_count !== e.rc) begin
          miscompares++;
          $display("FAIL vec%0d: got v=%b rw=%b rd=%0d m2r=%b imm=%h alu=%h dm=%h pc=%h rc=%h ; exp v=%b rw=%b rd=%0d m2r=%b imm=%h alu=%h dm=%h pc=%h rc=%h",
                   e.tag, act.valid, act.rw, act.rd, act.m2r, act.imm, act.alu, act.dm, act.pc,
                   retire_count, e.s.valid, e.s.rw, e.s.rd, e.s.m2r, e.s.imm, e.s.alu,
                   e.s.dm, e.s.pc, e.rc);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    slot_t z, a, b, b_exp, c, d, e, f, g, h, i, j, k, s;
    logic [15:0] v;

    rst = 1'b1; stall = 1'b0; flush = 1'b0; valid_in = 1'b0;
    alu_out_in = '0; dm_data_in = '0; PC_plus_2_in = '0; Imm2_in = '0;
    MemtoReg_in = '0; RegWrite_in = 1'b0; rd_in = '0;

    z     = '0;
    a     = mk(1, 1, 3'd5, 2'b00, 9'h1A5, 16'h1234, 16'h0F0F, 16'h0102);
    b     = mk(0, 1, 3'd2, 2'b01, 9'h033, 16'h7777, 16'h8888, 16'h0104);
    b_exp = mk(0, 0, 3'd2, 2'b01, 9'h033, 16'h7777, 16'h8888, 16'h0104);
    c     = mk(1, 1, 3'd3, 2'b10, 9'h0FF, 16'hABCD, 16'h1111, 16'h0106);
    d     = mk(1, 0, 3'd6, 2'b11, 9'h100, 16'h5555, 16'h2222, 16'h0108);
    e     = mk(1, 1, 3'd7, 2'b01, 9'h001, 16'h0001, 16'hFFFF, 16'h010A);
    f     = mk(1, 1, 3'd4, 2'b10, 9'h1FF, 16'hDEAD, 16'hBEEF, 16'h010C);
    g     = mk(1, 1, 3'd1, 2'b00, 9'h055, 16'h8000, 16'h0000, 16'h010E);
    h     = mk(1, 1, 3'd2, 2'b11, 9'h0AA, 16'hCAFE, 16'h1234, 16'h0110);
    i     = mk(1, 1, 3'd0, 2'b01, 9'h111, 16'h4321, 16'h5678, 16'h0112);
    j     = mk(1, 1, 3'd5, 2'b10, 9'h0C3, 16'h9999, 16'hAAAA, 16'h0114);
    k     = mk(1, 1, 3'd3, 2'b00, 9'h13C, 16'h2468, 16'h1357, 16'h0116);

    // Reset for two edges with live-looking inputs: everything must be zero.
    drive(1, 0, 0, a, z, 16'd0);
    drive(1, 1, 1, a, z, 16'd0);
    // Plain load, one-cycle latency.
    drive(0, 0, 0, a, a, 16'd0);
    // Bubble with RegWrite_in=1: RegWrite stays low; A retires.
    drive(0, 0, 0, b, b_exp, 16'd1);
    // Load 0xABCD; the bubble leaves without counting.
    drive(0, 0, 0, c, c, 16'd1);
    // Three stalled cycles with 0x5555 on the inputs: hold 0xABCD, no count.
    drive(0, 1, 0, d, c, 16'd1);
    drive(0, 1, 0, d, c, 16'd1);
    drive(0, 1, 0, d, c, 16'd1);
    // Stall drops: 0x5555 appears (RegWrite_in=0 -> RegWrite 0); C retires.
    drive(0, 0, 0, d, d, 16'd2);
    drive(0, 0, 0, e, e, 16'd3);
    // Flush and stall together: squash to zero, no retire because stalled.
    drive(0, 1, 1, f, z, 16'd3);
    // Stall on a bubble: bubble held, no count.
    drive(0, 1, 0, f, z, 16'd3);
    drive(0, 0, 0, g, g, 16'd3);
    // Flush alone: G leaves (counted), incoming H squashed.
    drive(0, 0, 1, h, z, 16'd4);
    drive(0, 0, 0, i, i, 16'd4);
    drive(0, 1, 0, j, i, 16'd4);
    // Reset while stalled on a valid instruction: all outputs cleared.
    drive(1, 1, 0, j, z, 16'd0);
    // First edge after reset is a normal load.
    drive(0, 0, 0, k, k, 16'd0);
    drive(0, 0, 0, z, z, 16'd1);

    // Wrap: the WB slot is a bubble, so after the n-th consecutive valid load
    // n-1 instructions have retired on top of the 1 already counted.
    for (int n = 1; n <= 65536; n++) begin
      v = n[15:0];
      s = mk(1, 1, v[2:0], v[1:0], v[8:0], v, ~v, v + 16'd2);
      drive(0, 0, 0, s, s, v);   // n=65535 -> 0xFFFF, n=65536 -> 0x0000
    end
    drive(0, 0, 0, z, z, 16'd1);

    // Drain the scoreboard.
    repeat (3) @(posedge clk);
    #3;
    vectors_applied++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_wb_reg.md
MEM_WB_REG -- requirements
Module: mem_wb_reg

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous, active-high reset, rst.
REQ-002 Port list SHALL be (name  direction  width  meaning):
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- stall  input  1  hold current WB-stage contents
- flush  input  1  squash the instruction entering WB
- valid_in  input  1  MEM stage holds a real instruction
- alu_out_in  input  16  ALU result from MEM
- dm_data_in  input  16  data-memory read data
- PC_plus_2_in  input  16  link address
- Imm2_in  input  9  LLI immediate
- MemtoReg_in  input  2  write-back select code
- RegWrite_in  input  1  register-write request
- rd_in  input  3  destination register index
- alu_out, dm_data, PC_plus_2  output  16 each  registered copies
- Imm2  output  9  registered copy
- MemtoReg  output  2  registered copy
- rd  output  3  registered copy
- valid_out  output  1  WB stage holds a real instruction
- RegWrite  output  1  qualified write enable to register file
- retire_count  output  16  retired-instruction counter

Function
REQ-003 All state SHALL update only on the rising edge of clk; there SHALL be no combinational path from any input to any output.
REQ-004 Per-edge priority SHALL be rst > flush > stall > load.
REQ-005 Load (no rst, flush or stall): every registered output SHALL take its _in value; valid_out SHALL take valid_in; latency is exactly one cycle.
REQ-006 Stall: every registered output, valid_out and rd SHALL hold its previous value.
REQ-007 Flush: valid_out SHALL become 0, and all data/control outputs SHALL become 0. The flush SHALL take effect even when stall is also asserted.
REQ-008 RegWrite output SHALL equal the registered RegWrite_in ANDed with valid_out. An invalid slot SHALL never assert RegWrite.
REQ-009 MemtoReg, Imm2 and the three 16-bit data outputs SHALL pass unmodified; no width change or sign extension SHALL occur in this block.
REQ-010 retire_count SHALL increment by 1 on each edge where valid_out=1, stall=0 and rst=0. This means the WB instruction leaves the stage, including when flush is asserted on that edge.
REQ-011 retire_count SHALL wrap from 0xFFFF to 0x0000 with no flag or saturation.
REQ-012 Stall while valid_out=0 SHALL hold the bubble and SHALL NOT increment retire_count.
REQ-013 Whenever RegWrite=0, rd SHALL be treated as don't-care downstream; the block nevertheless SHALL drive the registered value deterministically.

Reset
REQ-014 On an edge with rst=1, all outputs SHALL become 0, including valid_out, RegWrite and retire_count, regardless of stall, flush or valid_in.
REQ-015 Reset asserted mid-stall SHALL discard the held instruction. The first edge after rst deasserts SHALL perform a normal load.
REQ-016 Outputs before the first reset edge SHALL be treated as unknown; the bench SHALL apply rst for at least 2 cycles.

Verification
REQ-017 Load: valid_in=1, RegWrite_in=1, rd_in=5, alu_out_in=0x1234, MemtoReg_in=00 -> one edge later alu_out=0x1234, rd=5, RegWrite=1, valid_out=1; retire_count increments on the following edge.
REQ-018 Stall: load 0xABCD, then stall=1 for 3 cycles while the inputs change to 0x5555 -> outputs hold 0xABCD; retire_count unchanged during stall; 0x5555 appears one edge after stall drops.
REQ-019 Flush with stall: valid instruction in WB, flush=1 and stall=1 on the same edge -> valid_out=0, RegWrite=0, all data 0; retire_count incremented only if valid_out was 1 and stall was 0 (here: no increment).
REQ-020 Bubble qualification: valid_in=0, RegWrite_in=1 -> RegWrite=0 and retire_count unchanged.
REQ-021 Wrap: preload by streaming 65535 valid instructions, then one more -> retire_count goes 0xFFFF to 0x0000.
REQ-022 Reset mid-operation: rst=1 during stall with a valid instruction held -> next edge all outputs 0; after release, the first valid_in=1 load appears after one cycle.
